// File: rtl/sqgen_tx_if.sv
// Handshake/bus bundle for the sqgen_tx serial pattern generator.
// The master side supplies the request and pattern set-up; the slave side
// (the generator) returns the serial stream and its status flags.
interface sqgen_tx_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 3,
    parameter int CNT_W = 4
);
    logic             start;
    logic             stop;
    logic [PAT_W-1:0] pat;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] reps;
    logic             dout;
    logic             dvalid;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, pat, len, reps,
        input  dout, dvalid, busy, done
    );

    modport slave (
        input  start, stop, pat, len, reps,
        output dout, dvalid, busy, done
    );
endinterface

// File: rtl/sqgen_tx.sv
// sqgen_tx: serial bit-pattern generator.
// Latches pattern, length and repeat count on start, then shifts the pattern
// out MSB-first, one bit per clock, all outputs registered.
// Optional macro SQGEN_TX_GAP_EN inserts a one-cycle GAP bubble between
// consecutive repetitions; without it repetitions are back-to-back.
module sqgen_tx #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 3,
    parameter int CNT_W = 4
) (
    input  logic        clk,
    input  logic        rst,   // asynchronous, active-low
    sqgen_tx_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
`ifdef SQGEN_TX_GAP_EN
        , GAP = 2'd3
`endif
    } state_t;

    state_t           state_reg, state_next;
    logic [PAT_W-1:0] pat_reg, pat_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [LEN_W-1:0] idx_reg, idx_next;
    logic [CNT_W-1:0] rep_reg, rep_next;   // 0 means continuous
    logic             dout_reg, dout_next;
    logic             dvalid_reg, dvalid_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic [LEN_W-1:0] len_clamped;

    // Lengths beyond the pattern width can only occur when the len port is
    // wider than needed; clamp them to the top pattern bit.
    if ((1 << LEN_W) > PAT_W) begin : g_len_clamp
        assign len_clamped = (bus.len > LEN_W'(PAT_W - 1)) ? LEN_W'(PAT_W - 1) : bus.len;
    end else begin : g_len_pass
        assign len_clamped = bus.len;
    end

    // Next-state and next-output decode; stop overrides every state.
    always_comb begin
        state_next  = state_reg;
        pat_next    = pat_reg;
        len_next    = len_reg;
        idx_next    = idx_reg;
        rep_next    = rep_reg;
        dout_next   = 1'b0;
        dvalid_next = 1'b0;
        busy_next   = 1'b0;
        done_next   = 1'b0;
        if (bus.stop) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        pat_next    = bus.pat;
                        len_next    = len_clamped;
                        rep_next    = bus.reps;
                        idx_next    = len_clamped;
                        state_next  = SHIFT;
                        dout_next   = bus.pat[len_clamped];
                        dvalid_next = 1'b1;
                        busy_next   = 1'b1;
                    end
                end
                SHIFT: begin
                    busy_next = 1'b1;
                    if (idx_reg != '0) begin
                        idx_next    = idx_reg - 1'b1;
                        dout_next   = pat_reg[idx_next];
                        dvalid_next = 1'b1;
                    end else if (rep_reg != CNT_W'(1)) begin
                        // Another repetition follows: either continuous mode
                        // (count held at 0) or more than one left. Only a
                        // count above 1 is ever decremented, so it never wraps.
                        if (rep_reg != '0) begin
                            rep_next = rep_reg - CNT_W'(1);
                        end
                        idx_next = len_reg;
`ifdef SQGEN_TX_GAP_EN
                        state_next = GAP;
`else
                        dout_next   = pat_reg[len_reg];
                        dvalid_next = 1'b1;
`endif
                    end else begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end
                end
`ifdef SQGEN_TX_GAP_EN
                GAP: begin
                    state_next  = SHIFT;
                    busy_next   = 1'b1;
                    dout_next   = pat_reg[len_reg];
                    dvalid_next = 1'b1;
                end
`endif
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered outputs; reset clears everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            pat_reg    <= '0;
            len_reg    <= '0;
            idx_reg    <= '0;
            rep_reg    <= '0;
            dout_reg   <= 1'b0;
            dvalid_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pat_reg    <= pat_next;
            len_reg    <= len_next;
            idx_reg    <= idx_next;
            rep_reg    <= rep_next;
            dout_reg   <= dout_next;
            dvalid_reg <= dvalid_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    assign bus.dout   = dout_reg;
    assign bus.dvalid = dvalid_reg;
    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;

endmodule

// File: tb/tb_sqgen_tx.sv
// Self-checking bench for sqgen_tx: table vectors, hand-written corner
// sequences and randomized runs checked against a queue-based stream model.
// Honours SQGEN_TX_GAP_EN when the design is built with it.
module tb_sqgen_tx;

    localparam int PAT_W = 8;
    localparam int LEN_W = 3;
    localparam int CNT_W = 4;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    // Expected observation per cycle: {dvalid, dout, done, busy}
    logic [3:0] exp_q[$];

    sqgen_tx_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    sqgen_tx #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pat;
        logic [2:0]  len;
        logic [3:0]  reps;
        logic [31:0] bits;   // expected dout stream, first bit in bits[n-1]
        int          n;
    } vec_t;

    vec_t tbl[5];

    function automatic logic [3:0] obs();
        return {bus.dvalid, bus.dout, bus.done, bus.busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t: dvalid,dout,done,busy got=%b required=%b", name, $time, got, want);
        end else begin
            $display("ok   %s t=%0t: %b", name, $time, got);
        end
    endtask

    // Reference stream: every repetition sends bits len..0 of the pattern,
    // optional bubble between repetitions, then one done cycle, then idle.
    task automatic build_exp(input logic [7:0] p, input int l, input int r);
        int lc;
        lc = (l > PAT_W - 1) ? PAT_W - 1 : l;
        exp_q.delete();
        for (int k = 0; k < r; k++) begin
            for (int i = lc; i >= 0; i--) exp_q.push_back({1'b1, p[i], 1'b0, 1'b1});
`ifdef SQGEN_TX_GAP_EN
            if (k != r - 1) exp_q.push_back(4'b0001);
`endif
        end
        exp_q.push_back(4'b0011);
        exp_q.push_back(4'b0000);
    endtask

    // mode 0: inputs quiet after start; 1: random noise on inputs while busy;
    // 2: repeated start with pat=FF while busy.
    task automatic run_seq(input string name, input logic [7:0] p, input logic [2:0] l,
                           input logic [3:0] r, input int mode);
        build_exp(p, int'(l), int'(r));
        bus.pat = p; bus.len = l; bus.reps = r; bus.stop = 1'b0; bus.start = 1'b1;
        for (int j = 0; j < exp_q.size(); j++) begin
            tick();
            chk(name, obs(), exp_q[j]);
            if (exp_q[j][0]) begin
                if (mode == 1) begin
                    bus.start = 1'($urandom);
                    bus.pat   = 8'($urandom);
                    bus.len   = 3'($urandom);
                    bus.reps  = 4'($urandom);
                end else if (mode == 2) begin
                    bus.start = 1'b1; bus.pat = 8'hFF; bus.len = 3'd7; bus.reps = 4'd0;
                end else begin
                    bus.start = 1'b0;
                end
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int dv_seen;
        int len_i;

        tbl[0] = '{8'h0B, 3'd3, 4'd2, 32'b10111011,  8};
        tbl[1] = '{8'h01, 3'd0, 4'd1, 32'b1,         1};
        tbl[2] = '{8'hA5, 3'd7, 4'd1, 32'hA5,        8};
        tbl[3] = '{8'h06, 3'd2, 4'd3, 32'b110110110, 9};
        tbl[4] = '{8'h05, 3'd2, 4'd3, 32'b101101101, 9};

        bus.start = 1'b0; bus.stop = 1'b0; bus.pat = '0; bus.len = '0; bus.reps = '0;
        rst = 1'b0;
        #12;
        chk("reset_state", obs(), 4'b0000);
        rst = 1'b1;
        tick();
        chk("idle_after_reset", obs(), 4'b0000);

        // Table-driven vectors
        for (int v = 0; v < 5; v++) begin
            len_i = int'(tbl[v].len) + 1;
            bus.pat = tbl[v].pat; bus.len = tbl[v].len; bus.reps = tbl[v].reps;
            bus.start = 1'b1;
            for (int k = 0; k < tbl[v].n; k++) begin
`ifdef SQGEN_TX_GAP_EN
                if (k > 0 && (k % len_i) == 0) begin
                    tick();
                    chk($sformatf("tbl%0d_gap", v), obs(), 4'b0001);
                end
`endif
                tick();
                bus.start = 1'b0;
                chk($sformatf("tbl%0d_bit%0d", v, k), obs(), {1'b1, tbl[v].bits[tbl[v].n - 1 - k], 2'b01});
            end
            tick();
            chk($sformatf("tbl%0d_done", v), obs(), 4'b0011);
            tick();
            chk($sformatf("tbl%0d_idle", v), obs(), 4'b0000);
        end

        // Start while busy: stream must be the first pattern
        run_seq("start_busy", 8'h0B, 3'd3, 4'd1, 2);

        // Simultaneous start+stop in IDLE stays idle
        bus.pat = 8'h0F; bus.len = 3'd3; bus.reps = 4'd1; bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        chk("start_stop_idle", obs(), 4'b0000);
        bus.start = 1'b0; bus.stop = 1'b0;
        tick();
        chk("start_stop_idle2", obs(), 4'b0000);

        // Continuous mode, stop after 10 data cycles
        build_exp(8'h06, 2, 12);
        bus.pat = 8'h06; bus.len = 3'd2; bus.reps = 4'd0; bus.start = 1'b1;
        dv_seen = 0;
        for (int j = 0; j < 40 && dv_seen < 10; j++) begin
            tick();
            bus.start = 1'b0;
            chk("cont", obs(), exp_q[j]);
            if (bus.dvalid) dv_seen++;
        end
        checks++;
        if (dv_seen != 10) begin
            errors++;
            $display("FAIL cont_count: dvalid cycles got=%0d required=10", dv_seen);
        end
        bus.stop = 1'b1;
        tick();
        chk("cont_stop", obs(), 4'b0000);
        bus.stop = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("cont_after_stop", obs(), 4'b0000);
        end

        // Stop on the final bit suppresses done
        bus.pat = 8'h03; bus.len = 3'd1; bus.reps = 4'd1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("laststop_b1", obs(), 4'b1101);
        tick();
        chk("laststop_b0", obs(), 4'b1101);
        bus.stop = 1'b1;
        tick();
        chk("laststop_abort", obs(), 4'b0000);
        bus.stop = 1'b0;
        tick();
        chk("laststop_nodone", obs(), 4'b0000);

`ifdef SQGEN_TX_GAP_EN
        // Stop while in the inter-repetition bubble
        bus.pat = 8'h05; bus.len = 3'd2; bus.reps = 4'd2; bus.start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            bus.start = 1'b0;
        end
        tick();
        chk("gapstop_gap", obs(), 4'b0001);
        bus.stop = 1'b1;
        tick();
        chk("gapstop_abort", obs(), 4'b0000);
        bus.stop = 1'b0;
        tick();
        chk("gapstop_idle", obs(), 4'b0000);
`endif

        // Asynchronous reset during bit 3 of F0
        bus.pat = 8'hF0; bus.len = 3'd7; bus.reps = 4'd1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("rst_bit3", obs(), 4'b1001);
        #3 rst = 1'b0;
        #1;
        chk("rst_async", obs(), 4'b0000);
        #2 rst = 1'b1;
        tick();
        chk("rst_release_idle", obs(), 4'b0000);
        run_seq("after_rst", 8'hF0, 3'd7, 4'd1, 0);

        // Maximum repeat count must not wrap
        run_seq("reps_max", 8'h02, 3'd1, 4'd15, 0);

        // Randomized runs with input noise while busy
        for (int n = 0; n < 20; n++) begin
            run_seq($sformatf("rand%0d", n), 8'($urandom), 3'($urandom_range(0, 7)),
                    4'($urandom_range(1, 4)), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sqgen_tx.md
Name: sqgen_tx

Overview:
- Serial bit-pattern generator; the transmit-side counterpart of the serial sequence detector on the same single-bit serial link.
- Latches a programmable pattern, length and repeat count on start, then shifts the pattern out MSB-first, one bit per clock.
- Drives detector stimulus and loopback on the serial din line; outputs are registered.

Parameters:
- PAT_W, 8, maximum pattern width in bits.
- LEN_W, 3, width of len port; must satisfy 2**LEN_W >= PAT_W.
- CNT_W, 4, width of repeat counter / reps port.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request transmission; sampled only in IDLE.
- stop  input  1  synchronous abort, any state.
- pat  input  PAT_W  pattern; bits pat[len]..pat[0] are sent, pat[len] first.
- len  input  LEN_W  pattern length minus 1 (0 = 1 bit); values >= PAT_W clamp to PAT_W-1.
- reps  input  CNT_W  repetitions; 0 = continuous until stop.
- dout  output  1  serial data; 0 whenever dvalid=0.
- dvalid  output  1  dout carries a pattern bit this cycle.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after final bit of final repetition.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; dout=0, dvalid=0, busy=0, done=0; internal pattern, bit index and repeat registers cleared. Reset wins over everything, including mid-transmission; no done pulse.
- States: IDLE, SHIFT, GAP (GAP exists only with the optional feature), DONE.
- IDLE: if start=1 and stop=0 at an edge, latch pat, clamped len and reps, set bit index to len, go to SHIFT. dvalid=1 with dout=pat[len] after that same edge, giving 1-cycle latency from sampled start to first bit.
- SHIFT: each edge decrements the bit index; dout = latched pat[index]. After the bit with index 0:
  - if reps=0, or remaining repetitions > 1: reload index=len, decrement the repeat count (unless continuous) and keep shifting with no bubble.
  - else go to DONE.
- DONE: dvalid=0, dout=0, done=1, busy=1 for exactly one cycle, then IDLE.
- Bits transmitted = (len+1)*reps. done asserts the cycle after the last dvalid cycle.
- start is ignored while busy=1. pat, len and reps may change freely after the start edge without effect.
- stop=1 at any edge: go to IDLE; dvalid, dout, done and busy all 0 after that edge; no done pulse. stop has priority over start and over the DONE transition.
- Repeat counter must not wrap: reps=2**CNT_W-1 sends exactly that many repetitions.

Optional Feature:
- Macro SQGEN_TX_GAP_EN.
- Defined: between consecutive repetitions the FSM spends exactly one cycle in GAP (dvalid=0, dout=0, busy=1), giving receivers a resync bubble. No GAP occurs after the final repetition, and stop in GAP aborts as normal.
- Undefined: the GAP state and its logic are absent; repetitions are back-to-back.

Test Plan:
- Basic, two repetitions: pat=8'h0B, len=3, reps=2, start pulse at edge 0 → edges 1-8 give dvalid=1 with dout=1,0,1,1,1,0,1,1; done=1 for the cycle after edge 9, then busy=0.
- Single bit: pat=8'h01, len=0, reps=1 → one dvalid cycle with dout=1, then done. Also len=7, pat=8'hA5 → 1,0,1,0,0,1,0,1.
- Continuous and stop: reps=0, pat=8'h06, len=2 → repeating 1,1,0; assert stop after 10 dvalid cycles → next edge dvalid=0, busy=0, done never pulses.
- Start while busy: second start with pat=8'hFF mid-transmission → output stream unchanged from the first pattern. Simultaneous start+stop in IDLE → remains IDLE.
- Reset mid-run: drop rst during bit 3 of pat=8'hF0, len=7 → outputs 0 immediately, without waiting for a clock edge. After rst release, a new start transmits correctly from bit 7.
- With SQGEN_TX_GAP_EN: pat=8'h05, len=2, reps=3 → 1,0,1,gap,1,0,1,gap,1,0,1, then done; 11 busy cycles before DONE.
